// File: rtl/line_presence_tracker.sv
// Multi-line I-cache presence tracker: per-line free/pending/valid state with
// same-cycle "here" / "will be here" lookup, line allocation, fill completion and flush.

package mmm_pkg;
  parameter int XLEN          = 32;
  parameter int ICACHE_OFFSET = 4;
endpackage

module line_presence_tracker #(
  parameter int XLEN   = mmm_pkg::XLEN,
  parameter int OFFSET = mmm_pkg::ICACHE_OFFSET,
  parameter int NLINES = 4,
  localparam int IW    = $clog2(NLINES)
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic [XLEN-1:0] pc_i,
  output logic            here_o,
  output logic            will_be_here_o,
  output logic [IW-1:0]   hit_idx_o,
  input  logic            req_valid_i,
  input  logic [XLEN-1:0] req_addr_i,
  output logic            req_ready_o,
  output logic            req_alloc_o,
  output logic [IW-1:0]   alloc_idx_o,
  input  logic            fill_valid_i,
  input  logic [IW-1:0]   fill_idx_i,
  input  logic            flush_i,
  output logic [IW:0]     pending_cnt_o,
  output logic            err_o
);

  localparam int TW = XLEN - OFFSET;

  logic [TW-1:0]     tag_q [NLINES];
  logic [TW-1:0]     tag_d [NLINES];
  logic [NLINES-1:0] valid_q, valid_d;
  logic [NLINES-1:0] pending_q, pending_d;
  logic [NLINES-1:0] stale_q, stale_d;
  logic [IW-1:0]     rr_ptr_q, rr_ptr_d;
  logic              err_q, err_d;
  logic [IW:0]       cnt_q, cnt_d;

  logic [TW-1:0] pc_tag, req_tag;
  logic          will_any;
  logic          dup_hit;
  logic [IW-1:0] dup_idx;
  logic          victim_found;
  logic [IW-1:0] victim_idx, scan_idx;
  logic          unused_offset_bits;

  assign pc_tag  = pc_i[XLEN-1:OFFSET];
  assign req_tag = req_addr_i[XLEN-1:OFFSET];
  assign unused_offset_bits = ^{pc_i[OFFSET-1:0], req_addr_i[OFFSET-1:0]};

  // A stale pending line may share its tag with a newer live line, so only
  // valid or non-stale pending lines are allowed to match.
  always_comb begin
    here_o    = 1'b0;
    will_any  = 1'b0;
    hit_idx_o = '0;
    for (int i = 0; i < NLINES; i++) begin
      if (tag_q[i] == pc_tag) begin
        if (valid_q[i]) begin
          here_o    = 1'b1;
          hit_idx_o = IW'(i);
        end else if (pending_q[i] && !stale_q[i]) begin
          will_any  = 1'b1;
          hit_idx_o = IW'(i);
        end
      end
    end
    will_be_here_o = will_any & ~here_o;
  end

  always_comb begin
    dup_hit = 1'b0;
    dup_idx = '0;
    for (int i = 0; i < NLINES; i++) begin
      if ((tag_q[i] == req_tag) && (valid_q[i] || (pending_q[i] && !stale_q[i]))) begin
        dup_hit = 1'b1;
        dup_idx = IW'(i);
      end
    end
  end

  // Round-robin victim search; the index wraps naturally because NLINES is a power of two.
  always_comb begin
    victim_found = 1'b0;
    victim_idx   = rr_ptr_q;
    scan_idx     = rr_ptr_q;
    for (int k = 0; k < NLINES; k++) begin
      scan_idx = rr_ptr_q + IW'(k);
      if (!victim_found && !pending_q[scan_idx]) begin
        victim_found = 1'b1;
        victim_idx   = scan_idx;
      end
    end
  end

  assign req_ready_o   = ~flush_i & ~(&pending_q);
  assign req_alloc_o   = req_valid_i & req_ready_o & ~dup_hit;
  assign alloc_idx_o   = dup_hit ? dup_idx : victim_idx;
  assign pending_cnt_o = cnt_q;
  assign err_o         = err_q;

  always_comb begin
    tag_d     = tag_q;
    valid_d   = valid_q;
    pending_d = pending_q;
    stale_d   = stale_q;
    rr_ptr_d  = rr_ptr_q;
    err_d     = err_q;

    if (flush_i) begin
      valid_d = '0;
      stale_d = stale_q | pending_q;
    end

    // A fill retires the line; flushed or stale data is dropped rather than made valid.
    if (fill_valid_i) begin
      if (pending_q[fill_idx_i]) begin
        pending_d[fill_idx_i] = 1'b0;
        valid_d[fill_idx_i]   = ~stale_q[fill_idx_i] & ~flush_i;
        stale_d[fill_idx_i]   = 1'b0;
      end else begin
        err_d = 1'b1;
      end
    end

    // The victim is never the line being filled: that line is pending pre-edge.
    if (req_alloc_o) begin
      tag_d[victim_idx]     = req_tag;
      pending_d[victim_idx] = 1'b1;
      valid_d[victim_idx]   = 1'b0;
      stale_d[victim_idx]   = 1'b0;
      rr_ptr_d              = victim_idx + IW'(1);
    end

    cnt_d = '0;
    for (int i = 0; i < NLINES; i++) begin
      cnt_d = cnt_d + {{IW{1'b0}}, pending_d[i]};
    end
  end

  // NOTE: state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int i = 0; i < NLINES; i++) begin
        tag_q[i] <= '0;
      end
      valid_q   <= '0;
      pending_q <= '0;
      stale_q   <= '0;
      rr_ptr_q  <= '0;
      err_q     <= 1'b0;
      cnt_q     <= '0;
    end else begin
      tag_q     <= tag_d;
      valid_q   <= valid_d;
      pending_q <= pending_d;
      stale_q   <= stale_d;
      rr_ptr_q  <= rr_ptr_d;
      err_q     <= err_d;
      cnt_q     <= cnt_d;
    end
  end

endmodule

// File: tb/tb_line_presence_tracker.sv
// Scoreboard bench for line_presence_tracker: a line-level reference model predicts each
// cycle's outputs, a monitor compares them on the falling edge.

module tb_line_presence_tracker;

  localparam int XLEN   = 32;
  localparam int OFFSET = 4;
  localparam int NLINES = 4;
  localparam int IW     = 2;

  logic            clk_i = 1'b0;
  logic            rst_ni = 1'b0;
  logic [XLEN-1:0] pc_i = '0;
  logic            here_o, will_be_here_o;
  logic [IW-1:0]   hit_idx_o;
  logic            req_valid_i = 1'b0;
  logic [XLEN-1:0] req_addr_i = '0;
  logic            req_ready_o, req_alloc_o;
  logic [IW-1:0]   alloc_idx_o;
  logic            fill_valid_i = 1'b0;
  logic [IW-1:0]   fill_idx_i = '0;
  logic            flush_i = 1'b0;
  logic [IW:0]     pending_cnt_o;
  logic            err_o;

  line_presence_tracker #(.XLEN(XLEN), .OFFSET(OFFSET), .NLINES(NLINES)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni), .pc_i(pc_i),
    .here_o(here_o), .will_be_here_o(will_be_here_o), .hit_idx_o(hit_idx_o),
    .req_valid_i(req_valid_i), .req_addr_i(req_addr_i), .req_ready_o(req_ready_o),
    .req_alloc_o(req_alloc_o), .alloc_idx_o(alloc_idx_o),
    .fill_valid_i(fill_valid_i), .fill_idx_i(fill_idx_i), .flush_i(flush_i),
    .pending_cnt_o(pending_cnt_o), .err_o(err_o)
  );

  always #5 clk_i = ~clk_i;

  typedef enum {L_FREE, L_PEND, L_VALID} lstate_e;
  typedef struct {
    lstate_e           st;
    bit                stale;
    logic [XLEN-OFFSET-1:0] tag;
  } line_t;

  typedef struct {
    bit here;
    bit will;
    int hit;
    bit ready;
    bit chk_alloc;
    bit alloc;
    int aidx;
    int cnt;
    bit err;
  } exp_t;

  line_t m_line [NLINES];
  int    m_rr;
  bit    m_err;
  exp_t  exp_q [$];
  int    checks = 0;
  int    errors = 0;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic void model_reset();
    for (int i = 0; i < NLINES; i++) m_line[i] = '{L_FREE, 1'b0, '0};
    m_rr  = 0;
    m_err = 1'b0;
  endfunction

  function automatic int model_pending();
    int n = 0;
    for (int i = 0; i < NLINES; i++) if (m_line[i].st == L_PEND) n++;
    return n;
  endfunction

  // One clock cycle: drive inputs, queue the predicted outputs, advance the model past the edge.
  task automatic step(input logic [XLEN-1:0] pc, input bit rv, input logic [XLEN-1:0] ra,
                      input bit fv, input int fi, input bit fl);
    exp_t e;
    logic [XLEN-OFFSET-1:0] pt, rt;
    bit dup, fill_ok, fill_stale;
    int didx, victim;
    @(posedge clk_i);
    #1;
    pc_i = pc; req_valid_i = rv; req_addr_i = ra;
    fill_valid_i = fv; fill_idx_i = IW'(fi); flush_i = fl;

    pt = pc[XLEN-1:OFFSET];
    rt = ra[XLEN-1:OFFSET];
    e = '{default: 0};
    dup = 1'b0; didx = 0; victim = -1;
    for (int i = 0; i < NLINES; i++) begin
      if (m_line[i].tag == pt && m_line[i].st == L_VALID) begin e.here = 1; e.hit = i; end
      else if (m_line[i].tag == pt && m_line[i].st == L_PEND && !m_line[i].stale) begin
        e.will = 1; e.hit = i;
      end
      if (m_line[i].tag == rt && (m_line[i].st == L_VALID ||
          (m_line[i].st == L_PEND && !m_line[i].stale))) begin dup = 1; didx = i; end
    end
    if (e.here) e.will = 0;
    for (int k = 0; k < NLINES; k++) begin
      int j = (m_rr + k) % NLINES;
      if (victim < 0 && m_line[j].st != L_PEND) victim = j;
    end
    e.ready     = !fl && (victim >= 0);
    e.cnt       = model_pending();
    e.err       = m_err;
    e.chk_alloc = rv && e.ready;
    e.alloc     = !dup;
    e.aidx      = dup ? didx : victim;
    exp_q.push_back(e);

    fill_ok    = fv && m_line[fi].st == L_PEND;
    fill_stale = m_line[fi].stale;
    if (fv && !fill_ok) m_err = 1'b1;
    if (fl) begin
      for (int i = 0; i < NLINES; i++) begin
        if (m_line[i].st == L_VALID) m_line[i].st = L_FREE;
        if (m_line[i].st == L_PEND)  m_line[i].stale = 1'b1;
      end
    end
    if (fill_ok) begin
      m_line[fi].st    = (fill_stale || fl) ? L_FREE : L_VALID;
      m_line[fi].stale = 1'b0;
    end
    if (e.chk_alloc && !dup) begin
      m_line[victim] = '{L_PEND, 1'b0, rt};
      m_rr = (victim + 1) % NLINES;
    end
  endtask

  task automatic idle(input logic [XLEN-1:0] pc);
    step(pc, 0, '0, 0, 0, 0);
  endtask

  task automatic req(input logic [XLEN-1:0] a);
    step(a, 1, a, 0, 0, 0);
  endtask

  task automatic fill(input logic [XLEN-1:0] pc, input int fi);
    step(pc, 0, '0, 1, fi, 0);
  endtask

  task automatic do_reset();
    @(posedge clk_i);
    #1;
    req_valid_i = 0; fill_valid_i = 0; flush_i = 0;
    rst_ni = 1'b0;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk_i);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        check("here_o", here_o, e.here);
        check("will_be_here_o", will_be_here_o, e.will);
        check("hit_idx_o", hit_idx_o, e.hit);
        check("req_ready_o", req_ready_o, e.ready);
        check("pending_cnt_o", pending_cnt_o, e.cnt);
        check("err_o", err_o, e.err);
        if (e.chk_alloc) begin
          check("req_alloc_o", req_alloc_o, e.alloc);
          check("alloc_idx_o", alloc_idx_o, e.aidx);
        end
      end
    end
  end

  initial begin : stimulus
    logic [XLEN-1:0] a, p;
    int budget;
    model_reset();
    repeat (2) @(negedge clk_i);
    rst_ni = 1'b1;

    // Reset state, then single-line fetch and fill.
    idle(32'h100);
    req(32'h100);
    idle(32'h10C);
    fill(32'h10C, 0);
    idle(32'h10C);

    // Fill all lines, stall, free line 2, reallocate it.
    do_reset();
    req(32'h100); req(32'h200); req(32'h300); req(32'h400);
    idle(32'h200);
    fill(32'h500, 2);
    req(32'h500);
    idle(32'h500);

    // Duplicate request on a pending line.
    do_reset();
    req(32'h100);
    req(32'h104);
    idle(32'h100);

    // Flush with a pending line; its late fill must not become valid.
    do_reset();
    req(32'h100);
    fill(32'h100, 0);
    req(32'h200);
    step(32'h200, 1, 32'h300, 0, 0, 1);
    idle(32'h200);
    fill(32'h200, 1);
    idle(32'h200);

    // Error on fill of a free line; fill and flush on the same edge.
    do_reset();
    fill(32'h100, 3);
    idle(32'h100);
    req(32'h100);
    step(32'h100, 0, '0, 1, 0, 1);
    idle(32'h100);
    do_reset();
    idle(32'h100);
    fill(32'h100, 1);
    idle(32'h100);

    // Randomised traffic over a small tag set to force hits, duplicates and evictions.
    do_reset();
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 299) == 0) do_reset();
      p = {24'h0, 4'($urandom_range(1, 6)), 4'($urandom_range(0, 15))};
      a = {24'h0, 4'($urandom_range(1, 6)), 4'($urandom_range(0, 15))};
      step(p, $urandom_range(0, 1) == 1, a, $urandom_range(0, 9) < 3,
           $urandom_range(0, NLINES - 1), $urandom_range(0, 19) == 0);
    end
    idle(32'h0);

    budget = 0;
    while (exp_q.size() > 0 && budget < 20) begin
      @(negedge clk_i);
      budget++;
    end
    #1;
    if (exp_q.size() > 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
